// File: rtl/user_pulser_sequencer.sv
// ----------------------------------------------------------------------------
// user_pulser_sequencer
//
// Descriptor-driven front end for the user-domain pulse generator. Complete
// pulse programs are pushed into a small FIFO. The sequencer pops one
// program, holds it on the generator configuration outputs, fires start_o,
// waits for the generator to report DONE, repeats the program (repeat+1 runs
// in total) with an idle gap between runs, then fetches the next program.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   enable_i               allows S_IDLE -> S_LOAD (fetch of new descriptors)
//   abort_i                cancel current program, flush FIFO, drive stop_o
//   push_valid_i/ready_o   descriptor push handshake
//   push_*_i               descriptor fields (counts, ends, switches, repeat,
//                          gap)
//   pulser_state_i         generator state (0 = IDLE, 4 = DONE)
//   start_o, stop_o        generator control
//   f1_cnt_o .. f2_switch_o held generator configuration
//   busy_o                 sequencer not idle
//   level_o                FIFO occupancy 0..DEPTH
//   run_done_o             one-cycle pulse when a descriptor's last run ends
//   seq_state_o            FSM state encoding (debug/observability)
//
// Handshake: a descriptor transfers on a rising clk_i edge where
// push_valid_i && push_ready_o are both high; push_valid_i must not depend on
// push_ready_o, and the descriptor fields are sampled at that same edge.
// ----------------------------------------------------------------------------
module user_pulser_sequencer #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    input  logic          abort_i,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [7:0]    push_f1_cnt_i,
    input  logic [7:0]    push_f2_cnt_i,
    input  logic [7:0]    push_stop_cnt_i,
    input  logic [15:0]   push_f1_end_i,
    input  logic [15:0]   push_f1_switch_i,
    input  logic [15:0]   push_f2_end_i,
    input  logic [15:0]   push_f2_switch_i,
    input  logic [7:0]    push_repeat_i,
    input  logic [15:0]   push_gap_i,
    input  logic [2:0]    pulser_state_i,
    output logic          start_o,
    output logic          stop_o,
    output logic [7:0]    f1_cnt_o,
    output logic [7:0]    f2_cnt_o,
    output logic [7:0]    stop_cnt_o,
    output logic [15:0]   f1_end_o,
    output logic [15:0]   f1_switch_o,
    output logic [15:0]   f2_end_o,
    output logic [15:0]   f2_switch_o,
    output logic          busy_o,
    output logic [AW:0]   level_o,
    output logic          run_done_o,
    output logic [2:0]    seq_state_o
);

    typedef struct packed {
        logic [7:0]  f1_cnt;
        logic [7:0]  f2_cnt;
        logic [7:0]  stop_cnt;
        logic [15:0] f1_end;
        logic [15:0] f1_switch;
        logic [15:0] f2_end;
        logic [15:0] f2_switch;
    } cfg_t;

    typedef struct packed {
        cfg_t        cfg;
        logic [7:0]  rep;
        logic [15:0] gap;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [2:0]  GEN_IDLE = 3'd0;
    localparam logic [2:0]  GEN_DONE = 3'd4;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_next_state;

    desc_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;

    cfg_t           r_cfg;
    logic [7:0]     r_rep_cnt;
    logic [15:0]    r_gap_reg;
    logic [15:0]    r_gap_cnt;

    desc_t          w_push_desc;
    desc_t          w_head;
    logic           w_full;
    logic           w_push;
    logic           w_pop;
    logic           w_gen_idle;
    logic           w_gen_done;

    assign w_push_desc = '{
        cfg: '{
            f1_cnt:    push_f1_cnt_i,
            f2_cnt:    push_f2_cnt_i,
            stop_cnt:  push_stop_cnt_i,
            f1_end:    push_f1_end_i,
            f1_switch: push_f1_switch_i,
            f2_end:    push_f2_end_i,
            f2_switch: push_f2_switch_i
        },
        rep: push_repeat_i,
        gap: push_gap_i
    };

    assign w_gen_idle   = (pulser_state_i == GEN_IDLE);
    assign w_gen_done   = (pulser_state_i == GEN_DONE);

    // ------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------
    assign w_full       = (r_level == FULL_LVL);
    assign push_ready_o = !w_full && !abort_i;
    assign w_push       = push_valid_i && push_ready_o;
    // S_LOAD is only entered with a non-empty FIFO, so no empty guard needed.
    assign w_pop        = (r_state == S_LOAD) && !abort_i;
    assign w_head       = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_desc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (abort_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (abort_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i && (r_level != '0)) begin
                        w_next_state = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_next_state = S_ARM;
                end
                S_ARM: begin
                    if (w_gen_idle) begin
                        w_next_state = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_gen_done) begin
                        if (r_rep_cnt == 8'd0) begin
                            w_next_state = S_IDLE;
                        end else if (r_gap_reg == 16'd0) begin
                            w_next_state = S_ARM;
                        end else begin
                            w_next_state = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // gap_cnt counts gap..1, giving exactly gap cycles here.
                    if (r_gap_cnt == 16'd1) begin
                        w_next_state = S_ARM;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        start_o    = 1'b0;
        run_done_o = 1'b0;
        if (!abort_i) begin
            start_o    = (r_state == S_ARM) && w_gen_idle;
            run_done_o = (r_state == S_WAIT) && w_gen_done && (r_rep_cnt == 8'd0);
        end
    end

    assign stop_o      = abort_i;
    assign busy_o      = (r_state != S_IDLE);
    assign seq_state_o = r_state;
    assign level_o     = r_level;

    // ------------------------------------------------------------------
    // Datapath: held configuration, repeat and gap counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg     <= '0;
            r_rep_cnt <= '0;
            r_gap_reg <= '0;
            r_gap_cnt <= '0;
        end else if (abort_i) begin
            // Configuration is deliberately retained across an abort.
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_cfg     <= w_head.cfg;
                    r_rep_cnt <= w_head.rep;
                    r_gap_reg <= w_head.gap;
                end
                S_WAIT: begin
                    if (w_gen_done && (r_rep_cnt != 8'd0)) begin
                        r_rep_cnt <= r_rep_cnt - 8'd1;
                        if (r_gap_reg != 16'd0) begin
                            r_gap_cnt <= r_gap_reg;
                        end
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign f1_cnt_o    = r_cfg.f1_cnt;
    assign f2_cnt_o    = r_cfg.f2_cnt;
    assign stop_cnt_o  = r_cfg.stop_cnt;
    assign f1_end_o    = r_cfg.f1_end;
    assign f1_switch_o = r_cfg.f1_switch;
    assign f2_end_o    = r_cfg.f2_end;
    assign f2_switch_o = r_cfg.f2_switch;

endmodule

// File: tb/tb_user_pulser_sequencer.sv
// ----------------------------------------------------------------------------
// tb_user_pulser_sequencer
//
// Bench for user_pulser_sequencer. A behavioural generator answers start_o
// with a run of (f1_cnt[2:0] + f2_cnt[2:0]) busy cycles followed by one DONE
// cycle. The reference model is an ordered queue of accepted descriptors:
// each descriptor must produce repeat+1 starts carrying its configuration,
// runs of one descriptor must be separated by exactly gap+1 cycles from the
// DONE cycle to the next start, and run_done_o must pulse exactly on the DONE
// cycle of the last run.
// ----------------------------------------------------------------------------
module tb_user_pulser_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 112;

  typedef struct packed {
    logic [7:0]  f1_cnt;
    logic [7:0]  f2_cnt;
    logic [7:0]  stop_cnt;
    logic [15:0] f1_end;
    logic [15:0] f1_switch;
    logic [15:0] f2_end;
    logic [15:0] f2_switch;
    logic [7:0]  rep;
    logic [15:0] gap;
  } desc_t;

  // ---------------- DUT signals ----------------
  logic        clk_i;
  logic        rst_ni;
  logic        enable_i;
  logic        abort_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [7:0]  push_f1_cnt_i, push_f2_cnt_i, push_stop_cnt_i;
  logic [15:0] push_f1_end_i, push_f1_switch_i, push_f2_end_i, push_f2_switch_i;
  logic [7:0]  push_repeat_i;
  logic [15:0] push_gap_i;
  logic [2:0]  pulser_state_i;
  logic        start_o, stop_o;
  logic [7:0]  f1_cnt_o, f2_cnt_o, stop_cnt_o;
  logic [15:0] f1_end_o, f1_switch_o, f2_end_o, f2_switch_o;
  logic        busy_o;
  logic [AW:0] level_o;
  logic        run_done_o;
  logic [2:0]  seq_state_o;

  user_pulser_sequencer #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .enable_i         (enable_i),
    .abort_i          (abort_i),
    .push_valid_i     (push_valid_i),
    .push_ready_o     (push_ready_o),
    .push_f1_cnt_i    (push_f1_cnt_i),
    .push_f2_cnt_i    (push_f2_cnt_i),
    .push_stop_cnt_i  (push_stop_cnt_i),
    .push_f1_end_i    (push_f1_end_i),
    .push_f1_switch_i (push_f1_switch_i),
    .push_f2_end_i    (push_f2_end_i),
    .push_f2_switch_i (push_f2_switch_i),
    .push_repeat_i    (push_repeat_i),
    .push_gap_i       (push_gap_i),
    .pulser_state_i   (pulser_state_i),
    .start_o          (start_o),
    .stop_o           (stop_o),
    .f1_cnt_o         (f1_cnt_o),
    .f2_cnt_o         (f2_cnt_o),
    .stop_cnt_o       (stop_cnt_o),
    .f1_end_o         (f1_end_o),
    .f1_switch_o      (f1_switch_o),
    .f2_end_o         (f2_end_o),
    .f2_switch_o      (f2_switch_o),
    .busy_o           (busy_o),
    .level_o          (level_o),
    .run_done_o       (run_done_o),
    .seq_state_o      (seq_state_o)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  desc_t         cur;
  logic          cur_active;
  logic          in_flight;
  logic          idle_next;
  int            runs_started;
  int            cyc;
  int            done_cyc;
  int            n_vec;
  int            n_err;

  // ---------------- generator model state ----------------
  logic          gen_en;
  logic          start_seen;
  logic          stop_seen;
  int            gen_busy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [87:0] cfg_of(input desc_t d);
    return {d.f1_cnt, d.f2_cnt, d.stop_cnt, d.f1_end, d.f1_switch, d.f2_end, d.f2_switch};
  endfunction

  function automatic logic [87:0] dut_cfg();
    return {f1_cnt_o, f2_cnt_o, stop_cnt_o, f1_end_o, f1_switch_o, f2_end_o, f2_switch_o};
  endfunction

  function automatic desc_t mk(input logic [7:0] f1c, input logic [7:0] f2c,
                               input logic [7:0] sc, input logic [15:0] f1e,
                               input logic [15:0] f1s, input logic [15:0] f2e,
                               input logic [15:0] f2s, input logic [7:0] rep,
                               input logic [15:0] gap);
    desc_t d;
    d = '{f1_cnt: f1c, f2_cnt: f2c, stop_cnt: sc, f1_end: f1e, f1_switch: f1s,
          f2_end: f2e, f2_switch: f2s, rep: rep, gap: gap};
    return d;
  endfunction

  function automatic desc_t rand_desc();
    return mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 8'($urandom_range(0, 2)),
              16'($urandom_range(0, 6)));
  endfunction

  // ---------------- generator model ----------------
  // Updates just after the active edge so the DUT always sees a settled value.
  always @(posedge clk_i) begin
    #1;
    if (gen_en && rst_ni) begin
      if (stop_seen) begin
        pulser_state_i = 3'd0;
        gen_busy = 0;
      end else if (start_seen) begin
        gen_busy = int'(cur.f1_cnt[2:0]) + int'(cur.f2_cnt[2:0]);
        if (gen_busy == 0) begin
          pulser_state_i = 3'd4;
        end else begin
          pulser_state_i = 3'd1;
          gen_busy = gen_busy - 1;
        end
      end else if (pulser_state_i == 3'd4) begin
        pulser_state_i = 3'd0;
      end else if (pulser_state_i == 3'd1) begin
        if (gen_busy == 0) pulser_state_i = 3'd4;
        else gen_busy = gen_busy - 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    logic exp_done;
    start_seen = start_o;
    stop_seen  = stop_o;
    if (rst_ni) begin
      cyc++;
      exp_done = 1'b0;
      if (idle_next) begin
        chk("idle_after_done_state", seq_state_o, 3'd0);
        chk("idle_after_done_busy", busy_o, 1'b0);
        idle_next = 1'b0;
      end
      if (start_o) begin
        if (!cur_active) begin
          if (exp_q.size() == 0) begin
            chk("spurious_start", start_o, 1'b0);
          end else begin
            cur = desc_t'(exp_q.pop_front());
            cur_active = 1'b1;
            runs_started = 0;
          end
        end else if (runs_started > 0) begin
          chk("gap_timing", cyc - done_cyc, int'(cur.gap) + 1);
        end
        if (cur_active) begin
          chk("cfg_at_start", dut_cfg(), cfg_of(cur));
          runs_started++;
          in_flight = 1'b1;
        end
      end else if (pulser_state_i == 3'd4 && in_flight && !abort_i) begin
        in_flight = 1'b0;
        done_cyc = cyc;
        chk("cfg_at_done", dut_cfg(), cfg_of(cur));
        if (runs_started == int'(cur.rep) + 1) begin
          exp_done = 1'b1;
          cur_active = 1'b0;
          idle_next = 1'b1;
        end
      end
      chk("run_done", run_done_o, exp_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive_desc(input desc_t d);
    push_f1_cnt_i    = d.f1_cnt;
    push_f2_cnt_i    = d.f2_cnt;
    push_stop_cnt_i  = d.stop_cnt;
    push_f1_end_i    = d.f1_end;
    push_f1_switch_i = d.f1_switch;
    push_f2_end_i    = d.f2_end;
    push_f2_switch_i = d.f2_switch;
    push_repeat_i    = d.rep;
    push_gap_i       = d.gap;
  endtask

  task automatic push_desc(input desc_t d);
    int t;
    t = 0;
    drive_desc(d);
    push_valid_i = 1'b1;
    @(negedge clk_i);
    while (!push_ready_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    if (!push_ready_o) chk("push_timeout", push_ready_o, 1'b1);
    else exp_q.push_back(DW'(d));
    step();
    push_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || cur_active) && t < budget) begin
      step();
      t++;
    end
    if (exp_q.size() != 0 || cur_active) chk("drain_timeout", 1'b1, 1'b0);
    repeat (3) step();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int t;
    t = 0;
    @(negedge clk_i);
    while (seq_state_o !== s && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    if (seq_state_o !== s) chk("wait_state_timeout", seq_state_o, s);
    step();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    desc_t d5;
    n_vec = 0; n_err = 0; cyc = 0; done_cyc = 0;
    cur = '0; cur_active = 1'b0; in_flight = 1'b0; idle_next = 1'b0;
    runs_started = 0; gen_busy = 0; start_seen = 1'b0; stop_seen = 1'b0;
    gen_en = 1'b1;
    enable_i = 1'b0; abort_i = 1'b0; push_valid_i = 1'b0;
    pulser_state_i = 3'd0;
    drive_desc('0);

    // Reset
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_state", seq_state_o, 3'd0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_level", level_o, 0);
    chk("rst_start", start_o, 1'b0);
    chk("rst_stop", stop_o, 1'b0);
    chk("rst_cfg", dut_cfg(), 88'h0);
    chk("rst_push_ready", push_ready_o, 1'b1);
    step();

    // Single descriptor
    enable_i = 1'b1;
    push_desc(mk(8'd2, 8'd0, 8'd0, 16'd4, 16'd2, 16'd0, 16'd0, 8'd0, 16'd0));
    wait_drain(300);

    // Repeats with gap
    push_desc(mk(8'd3, 8'd1, 8'd7, 16'h1234, 16'h0567, 16'h89ab, 16'h0cde, 8'd2, 16'd5));
    wait_drain(400);

    // FIFO full and pointer wrap
    enable_i = 1'b0;
    repeat (4) push_desc(rand_desc());
    @(negedge clk_i);
    chk("full_level", level_o, 4);
    chk("full_ready", push_ready_o, 1'b0);
    step();
    d5 = rand_desc();
    drive_desc(d5);
    push_valid_i = 1'b1;
    repeat (3) begin
      step();
      @(negedge clk_i);
      chk("full_hold_level", level_o, 4);
    end
    step();
    enable_i = 1'b1;
    push_desc(d5);
    repeat (3) push_desc(rand_desc());
    wait_drain(2000);

    // Abort mid-run with a second descriptor queued
    enable_i = 1'b0;
    push_desc(mk(8'd6, 8'd0, 8'd1, 16'd10, 16'd5, 16'd0, 16'd0, 8'd0, 16'd0));
    push_desc(mk(8'd2, 8'd2, 8'd2, 16'd3, 16'd3, 16'd3, 16'd3, 8'd1, 16'd2));
    enable_i = 1'b1;
    wait_state(3'd3, 100);
    abort_i = 1'b1;
    drive_desc(rand_desc());
    push_valid_i = 1'b1;
    @(negedge clk_i);
    chk("abort_stop", stop_o, 1'b1);
    chk("abort_push_ready", push_ready_o, 1'b0);
    chk("abort_start", start_o, 1'b0);
    step();
    exp_q.delete();
    cur_active = 1'b0; in_flight = 1'b0; idle_next = 1'b0;
    abort_i = 1'b0;
    push_valid_i = 1'b0;
    @(negedge clk_i);
    chk("abort_level", level_o, 0);
    chk("abort_state", seq_state_o, 3'd0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_stop_released", stop_o, 1'b0);
    repeat (10) step();

    // Generator not idle while armed
    gen_en = 1'b0;
    pulser_state_i = 3'd4;
    push_desc(mk(8'd1, 8'd1, 8'd0, 16'd9, 16'd8, 16'd7, 16'd6, 8'd0, 16'd0));
    wait_state(3'd2, 100);
    repeat (4) begin
      @(negedge clk_i);
      chk("armed_gen_busy_start", start_o, 1'b0);
      step();
    end
    pulser_state_i = 3'd0;
    @(negedge clk_i);
    chk("armed_gen_release_start", start_o, 1'b1);
    step();
    pulser_state_i = 3'd4;
    step();
    pulser_state_i = 3'd0;
    gen_en = 1'b1;
    wait_drain(100);

    // All-zero descriptor, two runs
    push_desc(mk(8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd1, 16'd0));
    wait_drain(100);

    // Randomised descriptors
    for (int i = 0; i < 10; i++) begin
      push_desc(rand_desc());
      repeat ($urandom_range(0, 3)) step();
    end
    wait_drain(3000);

    @(negedge clk_i);
    chk("end_level", level_o, 0);
    chk("end_state", seq_state_o, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
